// File: rtl/axi4l_pkg.sv
// rtl/axi4l_pkg.sv - shared AXI4-Lite types and constants for the command master
package axi4l_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    WR_B = 3'd2,
    RD_A = 3'd3,
    RD_R = 3'd4,
    RSP  = 3'd5
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/axi4l_cmd_master_if.sv
// rtl/axi4l_cmd_master_if.sv - AXI4-Lite AW/W/B/AR/R channel bundle with master/slave views
interface axi4l_cmd_master_if #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 32
);

  logic                    awvalid;
  logic                    awready;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    wvalid;
  logic                    wready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    bvalid;
  logic                    bready;
  logic [1:0]              bresp;
  logic                    arvalid;
  logic                    arready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    rvalid;
  logic                    rready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    output arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    input  arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

endinterface

// File: rtl/axi4l_cmd_master.sv
// rtl/axi4l_cmd_master.sv - single-outstanding AXI4-Lite master driven by a valid/ready command port
module axi4l_cmd_master
  import axi4l_pkg::*;
#(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [3:0]            cmd_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  axi4l_cmd_master_if.master    axi
);

  if (DATA_WIDTH != 32) begin : g_width_check
    $error("axi4l_cmd_master supports DATA_WIDTH == 32 only");
  end

  state_t state;
  logic   aw_done;
  logic   w_done;
  logic   aw_hs;
  logic   w_hs;
  logic   unused_resp_lsbs;

  assign axi.awprot = PROT_DEFAULT;
  assign axi.arprot = PROT_DEFAULT;

  assign aw_hs = axi.awvalid && axi.awready;
  assign w_hs  = axi.wvalid && axi.wready;

  // Only the error bit of a response is reported; OKAY/EXOKAY are both success.
  assign unused_resp_lsbs = axi.bresp[0] ^ axi.rresp[0];

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state       <= IDLE;
      cmd_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      axi.awvalid <= 1'b0;
      axi.awaddr  <= '0;
      axi.wvalid  <= 1'b0;
      axi.wdata   <= '0;
      axi.wstrb   <= '0;
      axi.bready  <= 1'b0;
      axi.arvalid <= 1'b0;
      axi.araddr  <= '0;
      axi.rready  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // cmd_ready comes up one cycle after reset release or response handoff.
          if (!cmd_ready) begin
            cmd_ready <= 1'b1;
          end else if (cmd_valid) begin
            cmd_ready <= 1'b0;
            if (cmd_we) begin
              axi.awaddr  <= cmd_addr;
              axi.wdata   <= cmd_wdata;
              axi.wstrb   <= cmd_wstrb;
              axi.awvalid <= 1'b1;
              axi.wvalid  <= 1'b1;
              aw_done     <= 1'b0;
              w_done      <= 1'b0;
              state       <= WR;
            end else begin
              axi.araddr  <= cmd_addr;
              axi.arvalid <= 1'b1;
              state       <= RD_A;
            end
          end
        end

        WR: begin
          if (aw_hs) begin
            axi.awvalid <= 1'b0;
            aw_done     <= 1'b1;
          end
          if (w_hs) begin
            axi.wvalid <= 1'b0;
            w_done     <= 1'b1;
          end
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            axi.bready <= 1'b1;
            state      <= WR_B;
          end
        end

        WR_B: begin
          if (axi.bvalid && axi.bready) begin
            rsp_err    <= axi.bresp[1];
            rsp_rdata  <= '0;
            rsp_valid  <= 1'b1;
            axi.bready <= 1'b0;
            state      <= RSP;
          end
        end

        RD_A: begin
          if (axi.arready) begin
            axi.arvalid <= 1'b0;
            axi.rready  <= 1'b1;
            state       <= RD_R;
          end
        end

        RD_R: begin
          // Read data is returned even on an error response.
          if (axi.rvalid && axi.rready) begin
            rsp_rdata  <= axi.rdata;
            rsp_err    <= axi.rresp[1];
            rsp_valid  <= 1'b1;
            axi.rready <= 1'b0;
            state      <= RSP;
          end
        end

        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
